// File: rtl/overlay_capture_ctrl_pkg.sv
// Shared definitions for the overlay capture controller: FSM encodings,
// history entry layout and the field positions of the val_s status word.
package overlay_capture_ctrl_pkg;

  // FSM state encodings (2-bit, kept as plain constants for legacy users)
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_TRIG    = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  // Bus field widths
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int FC_W   = 3;

  // One history entry: {addr, data, rw, fc}
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic [FC_W-1:0]   fc;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);  // 52

  // val_s layout: {8'h0, view_off(8), state(2), 3'b0, fc(3), 7'b0, rw}
  localparam int VS_RW_BIT    = 0;
  localparam int VS_FC_LSB    = 8;
  localparam int VS_STATE_LSB = 14;
  localparam int VS_VIEW_LSB  = 16;

  // Assemble the status word shown in the overlay S field
  function automatic logic [31:0] pack_status(input logic [7:0]      view,
                                              input logic [1:0]      state,
                                              input logic [FC_W-1:0] fc,
                                              input logic            rw);
    logic [31:0] s;
    s                       = '0;
    s[VS_VIEW_LSB  +: 8]    = view;
    s[VS_STATE_LSB +: 2]    = state;
    s[VS_FC_LSB    +: FC_W] = fc;
    s[VS_RW_BIT]            = rw;
    return s;
  endfunction

endpackage

// File: rtl/overlay_capture_ctrl_if.sv
// CPU bus-cycle observation interface: one completed bus cycle per
// bus_valid pulse. The CPU side (or a bench) is the master, the capture
// controller only listens.
interface overlay_capture_ctrl_if;
  import overlay_capture_ctrl_pkg::*;

  logic              bus_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_rw;
  logic [FC_W-1:0]   bus_fc;

  modport master (output bus_valid, bus_addr, bus_data, bus_rw, bus_fc);
  modport slave  (input  bus_valid, bus_addr, bus_data, bus_rw, bus_fc);

endinterface

// File: rtl/overlay_capture_ctrl_capture_ring.sv
// History ring storage: DEPTH x ENTRY_W simple dual-port RAM with a
// synchronous write port and a registered (1-cycle latency) read port.
module overlay_capture_ctrl_capture_ring
  import overlay_capture_ctrl_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  entry_t        i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output entry_t        o_rd_data
);

  entry_t r_mem [DEPTH];
  entry_t r_rd_data;

  // Write one captured bus cycle into the ring
  // NOTE: the array has no reset so it maps onto block RAM; the controller's
  // entry count tells readers which slots hold valid data. Sequential state
  // uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/overlay_capture_ctrl.sv
// Bus-cycle capture sequencer for the debug overlay A/D/S fields.
// Records bus cycles into a history ring until an address trigger (plus
// POST follow-on captures) or a manual freeze stops it, lets the user browse
// the history while stopped, and refreshes the display registers only on a
// synchronized vsync rising edge so the overlay never tears.
module overlay_capture_ctrl
  import overlay_capture_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,  // power of 2, 2..256
  parameter int POST  = 4    // captures after the trigger, 0..255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  overlay_capture_ctrl_if.slave  bus,
  input  logic                   trig_en,
  input  logic [ADDR_W-1:0]      trig_addr,
  input  logic [ADDR_W-1:0]      trig_mask,
  input  logic                   freeze,
  input  logic                   resume,
  input  logic                   step_older,
  input  logic                   step_newer,
  input  logic                   vs_in,
  output logic [31:0]            val_a,
  output logic [31:0]            val_d,
  output logic [31:0]            val_s,
  output logic                   stopped
);

  localparam int         AW     = $clog2(DEPTH);
  localparam int         CW     = AW + 1;
  localparam logic [7:0] POST_L = 8'(POST);

  // State
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_view_off;
  logic [7:0]    r_post_cnt;

  // vsync synchronizer and edge detect
  logic r_vs_meta;
  logic r_vs_sync;
  logic r_vs_prev;
  logic w_vs_rise;

  // Display registers
  logic [31:0] r_val_a;
  logic [31:0] r_val_d;
  logic [31:0] r_val_s;

  // Capture / trigger / browse decode
  logic          w_capture;
  logic          w_trig_hit;
  logic          w_can_older;
  logic [AW-1:0] w_rd_idx;
  entry_t        w_wr_entry;
  entry_t        w_rd_entry;

  assign w_capture  = bus.bus_valid && (r_state != ST_STOPPED);
  assign w_trig_hit = trig_en && (((bus.bus_addr ^ trig_addr) & trig_mask) == '0);
  assign w_wr_entry = '{addr: bus.bus_addr, data: bus.bus_data,
                        rw:   bus.bus_rw,   fc:   bus.bus_fc};

  // Browsing older is allowed while view_off + 1 still addresses a valid entry
  assign w_can_older = (({1'b0, r_view_off} + CW'(1)) < r_count);

  // Newest entry sits at wr_ptr-1; view_off walks back from there, wrapping
  assign w_rd_idx = r_wr_ptr - AW'(1) - r_view_off;

  assign w_vs_rise = r_vs_sync && !r_vs_prev;

  overlay_capture_ctrl_capture_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .i_wr_en   (w_capture),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_rd_entry)
  );

  // Next-state logic: resume beats freeze, freeze beats the trigger path
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred when a branch leaves the state alone.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (freeze && !resume) begin
          w_state_nxt = ST_STOPPED;
        end else if (w_capture && w_trig_hit) begin
          w_state_nxt = (POST == 0) ? ST_STOPPED : ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (resume) begin
          w_state_nxt = ST_RUN;
        end else if (freeze) begin
          w_state_nxt = ST_STOPPED;
        end else if (w_capture && (r_post_cnt <= 8'd1)) begin
          w_state_nxt = ST_STOPPED;
        end
      end
      ST_STOPPED: begin
        if (resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Post-trigger countdown: loaded by the trigger capture, one tick per capture in TRIG
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_post_cnt <= '0;
    end else if (w_capture) begin
      if ((r_state == ST_RUN) && w_trig_hit) begin
        r_post_cnt <= POST_L;
      end else if ((r_state == ST_TRIG) && (r_post_cnt != '0)) begin
        r_post_cnt <= r_post_cnt - 8'd1;
      end
    end
  end

  // Write pointer and saturating fill count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_capture) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_count != CW'(DEPTH)) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // History browse offset: live only while stopped, opposing steps cancel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_view_off <= '0;
    end else if ((r_state != ST_STOPPED) || resume) begin
      r_view_off <= '0;
    end else if (step_older && !step_newer && w_can_older) begin
      r_view_off <= r_view_off + AW'(1);
    end else if (step_newer && !step_older && (r_view_off != '0)) begin
      r_view_off <= r_view_off - AW'(1);
    end
  end

  // Two-flop vsync synchronizer plus delayed copy for rising-edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_meta <= vs_in;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  // Display registers: load once per frame, hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_val_a <= '0;
      r_val_d <= '0;
      r_val_s <= '0;
    end else if (w_vs_rise) begin
      if (r_count == '0) begin
        // Empty history: the ring slot holds no captured cycle, show zeros
        r_val_a <= '0;
        r_val_d <= '0;
        r_val_s <= pack_status(8'(r_view_off), r_state, 3'b000, 1'b0);
      end else begin
        r_val_a <= w_rd_entry.addr;
        r_val_d <= {16'h0, w_rd_entry.data};
        r_val_s <= pack_status(8'(r_view_off), r_state, w_rd_entry.fc, w_rd_entry.rw);
      end
    end
  end

  assign val_a   = r_val_a;
  assign val_d   = r_val_d;
  assign val_s   = r_val_s;
  assign stopped = (r_state == ST_STOPPED);

endmodule

// File: tb/tb_overlay_capture_ctrl.sv
// Directed bench for overlay_capture_ctrl. Two instances share all inputs:
// u_dut with POST=4 and u_dut_p0 with POST=0.
// Capture data rule: data = addr[15:0] ^ 16'h5A5A, rw = addr[0], fc = addr[3:1].
module tb_overlay_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_addr = '0;
  logic [31:0] trig_mask = '0;
  logic        freeze = 1'b0;
  logic        resume = 1'b0;
  logic        step_older = 1'b0;
  logic        step_newer = 1'b0;
  logic        vs_in = 1'b0;

  logic [31:0] a0, d0, s0, a1, d1, s1;
  logic        stp0, stp1;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] RUN = 2'd0, TRIG = 2'd1, STOP = 2'd2;

  always #5 clk = ~clk;

  overlay_capture_ctrl_if bus_if ();

  overlay_capture_ctrl #(.DEPTH(16), .POST(4)) u_dut (
    .clk (clk), .reset_n (reset_n), .bus (bus_if),
    .trig_en (trig_en), .trig_addr (trig_addr), .trig_mask (trig_mask),
    .freeze (freeze), .resume (resume),
    .step_older (step_older), .step_newer (step_newer), .vs_in (vs_in),
    .val_a (a0), .val_d (d0), .val_s (s0), .stopped (stp0)
  );

  overlay_capture_ctrl #(.DEPTH(16), .POST(0)) u_dut_p0 (
    .clk (clk), .reset_n (reset_n), .bus (bus_if),
    .trig_en (trig_en), .trig_addr (trig_addr), .trig_mask (trig_mask),
    .freeze (freeze), .resume (resume),
    .step_older (step_older), .step_newer (step_newer), .vs_in (vs_in),
    .val_a (a1), .val_d (d1), .val_s (s1), .stopped (stp1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_d(input logic [31:0] a);
    return {16'h0, a[15:0] ^ 16'h5A5A};
  endfunction

  function automatic logic [31:0] exp_s(input int view, input logic [1:0] st, input logic [31:0] a);
    logic [7:0] v;
    v = 8'(view);
    return {8'h00, v, st, 3'b000, a[3:1], 7'b0000000, a[0]};
  endfunction

  // Advance n clocks; return 1 time unit after the last rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] a);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_addr  = a;
    bus_if.bus_data  = a[15:0] ^ 16'h5A5A;
    bus_if.bus_rw    = a[0];
    bus_if.bus_fc    = a[3:1];
    tick(1);
    bus_if.bus_valid = 1'b0;
  endtask

  task automatic pulse(input logic f, input logic r, input logic so, input logic sn);
    freeze = f; resume = r; step_older = so; step_newer = sn;
    tick(1);
    freeze = 1'b0; resume = 1'b0; step_older = 1'b0; step_newer = 1'b0;
  endtask

  task automatic vsync();
    vs_in = 1'b1;
    tick(4);
    vs_in = 1'b0;
    tick(3);
  endtask

  initial begin
    bus_if.bus_valid = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_data  = '0;
    bus_if.bus_rw    = 1'b0;
    bus_if.bus_fc    = '0;

    // ---------------- reset state
    tick(3);
    check("rst_val_a", a0, 32'h0);
    check("rst_val_d", d0, 32'h0);
    check("rst_val_s", s0, 32'h0);
    check("rst_stopped", {31'b0, stp0}, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // ---------------- 1: reset in TRIG with count 5
    trig_en = 1'b1; trig_addr = 32'h00FA_0000; trig_mask = 32'hFFFF_0000;
    for (int i = 1; i <= 4; i++) capture(32'h00F9_0000 + 32'(i));
    capture(32'h00FA_0000);
    vsync();
    check("t1_trig_val_a", a0, 32'h00FA_0000);
    check("t1_trig_val_s", s0, exp_s(0, TRIG, 32'h00FA_0000));
    reset_n = 1'b0;
    #1;
    check("t1_async_val_a", a0, 32'h0);
    check("t1_async_val_d", d0, 32'h0);
    check("t1_async_val_s", s0, 32'h0);
    check("t1_async_stp_p0", {31'b0, stp1}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    trig_en = 1'b0;
    tick(2);
    vsync();
    check("t1_post_val_a", a0, 32'h0);
    check("t1_post_val_s", s0, 32'h0);

    // ---------------- 2: wraparound history and browse limits
    for (int i = 0; i < 20; i++) capture(32'h100 + 32'(i));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_stopped", {31'b0, stp0}, 32'h1);
    vsync();
    check("t2_newest_a", a0, 32'h113);
    check("t2_newest_d", d0, exp_d(32'h113));
    check("t2_newest_s", s0, exp_s(0, STOP, 32'h113));
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    check("t2_no_vsync_hold", a0, 32'h113);
    vsync();
    check("t2_older1", a0, 32'h112);
    for (int i = 0; i < 14; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vsync();
    check("t2_oldest_a", a0, 32'h104);
    check("t2_oldest_s", s0, exp_s(15, STOP, 32'h104));
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vsync();
    check("t2_sat_older_a", a0, 32'h104);
    check("t2_sat_older_s", s0, exp_s(15, STOP, 32'h104));
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    vsync();
    check("t2_newer", a0, 32'h105);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    vsync();
    check("t2_both_steps", s0, exp_s(14, STOP, 32'h105));

    // ---------------- 3/4: address trigger, POST=4 and POST=0
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_resumed", {31'b0, stp0}, 32'h0);
    trig_en = 1'b1;
    capture(32'h00F9_0100);
    capture(32'h00F9_0200);
    capture(32'h00F9_0300);
    check("t3_no_early_trig", {31'b0, stp1}, 32'h0);
    capture(32'h00FA_0010);
    check("t4_p0_stop_on_trig", {31'b0, stp1}, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      capture(32'h00FA_0020 + 32'(k));
      if (k == 3) check("t3_running_after_3", {31'b0, stp0}, 32'h0);
      if (k == 4) check("t3_stopped_after_4", {31'b0, stp0}, 32'h1);
    end
    vsync();
    check("t3_newest_a", a0, 32'h00FA_0024);
    check("t3_newest_s", s0, exp_s(0, STOP, 32'h00FA_0024));
    check("t4_p0_val_a", a1, 32'h00FA_0010);
    check("t4_p0_val_s", s1, exp_s(0, STOP, 32'h00FA_0010));
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vsync();
    check("t3_trig_at_view4", a0, 32'h00FA_0010);
    check("t3_view4_s", s0, exp_s(4, STOP, 32'h00FA_0010));
    check("t4_p0_view4", a1, 32'h113);

    // ---------------- 5: freeze+resume in TRIG, steps in RUN, capture in STOPPED
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    capture(32'h00FA_0030);
    vsync();
    check("t5_in_trig", s0, exp_s(0, TRIG, 32'h00FA_0030));
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_resume_wins", {31'b0, stp0}, 32'h0);
    trig_en = 1'b0;
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vsync();
    check("t5_run_view0_s", s0, exp_s(0, RUN, 32'h00FA_0030));
    check("t5_run_view0_a", a0, 32'h00FA_0030);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    capture(32'h0000_0777);
    vsync();
    check("t5_stopped_ignore", a0, 32'h00FA_0030);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    vsync();
    check("t5_wrptr_kept", a0, 32'h00FA_0024);

    // ---------------- 6: frame-stable display and vsync latency
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    capture(32'h0000_ABC0);
    tick(2);
    vsync();
    check("t6_first_frame", a0, 32'h0000_ABC0);
    capture(32'h0000_DEF0);
    tick(3);
    check("t6_midframe_a", a0, 32'h0000_ABC0);
    check("t6_midframe_d", d0, exp_d(32'h0000_ABC0));
    vs_in = 1'b1;
    tick(2);
    check("t6_not_yet", a0, 32'h0000_ABC0);
    tick(1);
    check("t6_at_3clk_a", a0, 32'h0000_DEF0);
    check("t6_at_3clk_d", d0, exp_d(32'h0000_DEF0));
    vs_in = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
